// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - 16x-oversampling UART receiver, optional parity via UART_RX_PARITY_EN
module uart_rx_oversample #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int SW = $clog2((OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK);
  localparam int NW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] MID_TICK  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state, state_n;
  logic                 sync1, rx_s, rx_prev;
  logic [SW-1:0]        s_cnt, s_cnt_n;
  logic [NW-1:0]        n_cnt, n_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 done_n;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_bit_n;
`endif

  // Two-flop synchroniser plus previous-value flop; reset to idle-high so release never looks like a start edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  // State, counters and shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      s_cnt   <= '0;
      n_cnt   <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      s_cnt   <= s_cnt_n;
      n_cnt   <= n_cnt_n;
      shreg   <= shreg_n;
`ifdef UART_RX_PARITY_EN
      par_bit <= par_bit_n;
`endif
    end
  end

  // Next-state logic: IDLE arms on an edge without a tick, every other decision waits for a tick
  always_comb begin
    state_n = state;
    s_cnt_n = s_cnt;
    n_cnt_n = n_cnt;
    shreg_n = shreg;
    done_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_n = par_bit;
`endif
    case (state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          state_n = START;
          s_cnt_n = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_cnt == MID_TICK) begin
            if (!rx_s) begin
              state_n = DATA;
              s_cnt_n = '0;
              n_cnt_n = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_cnt == BIT_LAST) begin
            shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
            s_cnt_n = '0;
            n_cnt_n = n_cnt + 1'b1;
            if (n_cnt == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_cnt == BIT_LAST) begin
            par_bit_n = rx_s;
            s_cnt_n   = '0;
            state_n   = STOP;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s_cnt == STOP_LAST) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output word and flags update one clk after the stop-sample tick; done is a single-cycle strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_done    <= 1'b0;
      rx_data    <= '0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      rx_done <= done_n;
      if (done_n) begin
        rx_data    <= shreg;
        frame_err  <= ~rx_s;
`ifdef UART_RX_PARITY_EN
        parity_err <= ((^shreg) ^ par_bit) != PARITY_ODD;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb/tb_uart_rx_oversample.sv - self-checking bench for uart_rx_oversample (tick every 4 clk, 16x oversample)
module tb_uart_rx_oversample;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       parity_err;

  uart_rx_oversample #(
    .DATA_BITS (8),
    .OVERSAMPLE(16),
    .SB_TICK   (16),
    .PARITY_ODD(1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .frame_err(frame_err)
  );

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  typedef struct {
    logic [7:0] d;
    bit         fe;
    bit         pe;
    longint     cyc;
  } rec_t;

  typedef struct {
    logic [7:0] d;
    bit         stop;
    logic [7:0] exp_d;
    bit         exp_fe;
  } vec_t;

  rec_t   got_q[$];
  rec_t   exp_q[$];
  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  bit     tick_hold = 1'b0;
  int     bit_clk = 64;
  bit     prev_done = 1'b0;

  always #5 clk = ~clk;

  // Tick generator: one tick every 4 clk, or held high
  initial begin
    int tdiv;
    tdiv = 0;
    forever begin
      @(negedge clk);
      if (tick_hold) tick = 1'b1;
      else begin
        tick = (tdiv == 0);
        tdiv = (tdiv + 1) % 4;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame collector; also checks the done strobe is never two cycles wide
  initial forever begin
    rec_t r;
    @(negedge clk);
    if (rx_done) begin
      r.d = rx_data; r.fe = frame_err; r.pe = parity_err; r.cyc = cyc;
      got_q.push_back(r);
      chk("done_width", prev_done, 0);
    end
    prev_done = rx_done;
  end

  task automatic send_bit(input bit b);
    rx = b;
    repeat (bit_clk) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * bit_clk) @(negedge clk);
  endtask

  // Line-level frame: start, LSB-first data, optional odd-parity bit (optionally corrupted), stop
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((~(^d)) ^ flip);
`endif
    send_bit(stop);
  endtask

  task automatic expect_frame(input logic [7:0] d, input bit fe, input bit pe);
    rec_t r;
    r.d = d; r.fe = fe; r.pe = pe; r.cyc = 0;
    exp_q.push_back(r);
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), got_q[i].d, exp_q[i].d);
      chk($sformatf("%s_ferr%0d", tag, i), got_q[i].fe, exp_q[i].fe);
`ifdef UART_RX_PARITY_EN
      chk($sformatf("%s_perr%0d", tag, i), got_q[i].pe, exp_q[i].pe);
`endif
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vec_t vecs[6];
    longint gap;

    vecs[0] = '{8'h12, 1'b1, 8'h12, 1'b0};
    vecs[1] = '{8'hFE, 1'b1, 8'hFE, 1'b0};
    vecs[2] = '{8'h80, 1'b0, 8'h80, 1'b1};
    vecs[3] = '{8'h01, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'hC3, 1'b0, 8'hC3, 1'b1};
    vecs[5] = '{8'h6D, 1'b1, 8'h6D, 1'b0};

    // Reset state
    #1;
    chk("reset_data", rx_data, 0);
    chk("reset_done", rx_done, 0);
    chk("reset_ferr", frame_err, 0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    idle_bits(1);

    // Single good frame, then idle
    expect_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle_bits(4);
    check_frames("t1");

    // Short low glitch rejected, then a real frame
    rx = 1'b0;
    repeat (20) @(negedge clk);
    idle_bits(2);
    chk("t2_glitch_count", got_q.size(), 0);
    expect_frame(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle_bits(2);
    check_frames("t2");

    // Framing error followed by a long break, then a good frame
    expect_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (160) @(negedge clk);
    idle_bits(1);
    expect_frame(8'h01, 1'b0, 1'b0);
    send_frame(8'h01, 1'b1, 1'b0);
    idle_bits(2);
    check_frames("t3");

    // Asynchronous reset in the middle of a frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    #2;
    reset = 1'b1;
    rx = 1'b1;
    #1;
    chk("t4_async_data", rx_data, 0);
    chk("t4_async_done", rx_done, 0);
    chk("t4_async_ferr", frame_err, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle_bits(1);
    expect_frame(8'hFF, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle_bits(2);
    check_frames("t4");

    // Back-to-back frames with no idle gap: done spacing is one full frame
    expect_frame(8'h00, 1'b0, 1'b0);
    expect_frame(8'h7E, 1'b0, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle_bits(2);
    gap = (got_q.size() >= 2) ? (got_q[1].cyc - got_q[0].cyc) : -1;
`ifdef UART_RX_PARITY_EN
    chk("t5_spacing", gap, 11 * 64);
`else
    chk("t5_spacing", gap, 10 * 64);
`endif
    check_frames("t5");

    // Tick held high: bit period collapses to 16 clk, done still a single pulse
    tick_hold = 1'b1;
    bit_clk = 16;
    idle_bits(1);
    expect_frame(8'h96, 1'b0, 1'b0);
    send_frame(8'h96, 1'b1, 1'b0);
    idle_bits(3);
    check_frames("thold");
    tick_hold = 1'b0;
    bit_clk = 64;
    idle_bits(1);

`ifdef UART_RX_PARITY_EN
    // Odd parity: 0x55 needs parity bit 1
    expect_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    idle_bits(1);
    expect_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'h55, 1'b1, 1'b1);
    idle_bits(2);
    check_frames("t6");
`endif

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      expect_frame(vecs[i].exp_d, vecs[i].exp_fe, 1'b0);
      send_frame(vecs[i].d, vecs[i].stop, 1'b0);
      idle_bits(2);
      check_frames($sformatf("vec%0d", i));
    end

    // Randomized frames against the line-level model
    for (int i = 0; i < 15; i++) begin
      logic [7:0] d;
      bit         stop;
      bit         flip;
      int         g;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      flip = 1'($urandom_range(0, 1));
      g    = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
`ifdef UART_RX_PARITY_EN
      expect_frame(d, !stop, flip);
`else
      expect_frame(d, !stop, 1'b0);
`endif
      send_frame(d, stop, flip);
      if (g > 0) idle_bits(g);
    end
    idle_bits(2);
    check_frames("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
